// File: rtl/pmem_scheduler.sv
// pmem_scheduler: shares one pmem port among demand, writeback and prefetch line requesters.
// Define PMEM_SCHED_PERF_EN to build the demand-wait and prefetch-grant counters.
module pmem_scheduler #(
   parameter int WIDTH      = 256,
   parameter int WB_AGE_MAX = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      dem_address,
   input  logic             dem_read,
   input  logic             dem_write,
   input  logic [WIDTH-1:0] dem_wdata,
   output logic [WIDTH-1:0] dem_rdata,
   output logic             dem_resp,
   input  logic [31:0]      wb_address,
   input  logic             wb_write,
   input  logic [WIDTH-1:0] wb_wdata,
   output logic             wb_resp,
   input  logic [31:0]      pf_address,
   input  logic             pf_read,
   output logic [WIDTH-1:0] pf_rdata,
   output logic             pf_resp,
   output logic [31:0]      pmem_address,
   output logic             pmem_read,
   output logic             pmem_write,
   output logic [WIDTH-1:0] pmem_wdata,
   input  logic [WIDTH-1:0] pmem_rdata,
   input  logic             pmem_resp,
   output logic [1:0]       grant,
   output logic [31:0]      perf_dem_wait,
   output logic [31:0]      perf_pf_grants
);
   typedef enum logic [1:0] {IDLE = 2'd0, DEM = 2'd1, WB = 2'd2, PF = 2'd3} state_t;
   localparam logic [3:0] AGE_MAX = 4'(WB_AGE_MAX);
   state_t state, state_nx;
   logic [31:0] addr_q;
   logic [WIDTH-1:0] wdata_q;
   logic rd_q, wr_q;
   logic [3:0] age;
   logic dem_req, wb_first;
   assign dem_req = dem_read | dem_write;
   // an aged writeback, or one holding the line a demand read wants, goes ahead of demand
   assign wb_first = wb_write && (age == AGE_MAX || (dem_read && dem_address[31:5] == wb_address[31:5]));
   assign pmem_address = addr_q;
   assign pmem_wdata = wdata_q;
   assign dem_rdata = pmem_rdata;
   assign pf_rdata = pmem_rdata;
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      if (state == IDLE)
         state_nx = wb_first ? WB : dem_req ? DEM : wb_write ? WB : pf_read ? PF : IDLE;
      else if (pmem_resp)
         state_nx = IDLE;
      grant = state;
      pmem_read = (state == DEM && rd_q) || state == PF;
      pmem_write = (state == DEM && wr_q) || state == WB;
      dem_resp = state == DEM && pmem_resp;
      wb_resp = state == WB && pmem_resp;
      pf_resp = state == PF && pmem_resp;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         addr_q <= '0;
         wdata_q <= '0;
         rd_q <= 1'b0;
         wr_q <= 1'b0;
         age <= '0;
      end else if (state == IDLE) begin
         if (state_nx == DEM) begin
            addr_q <= dem_address;
            rd_q <= dem_read;
            wr_q <= dem_write & ~dem_read;
            if (dem_write && !dem_read) wdata_q <= dem_wdata;
            if (wb_write && age != AGE_MAX) age <= age + 4'd1;
         end
         if (state_nx == WB) begin
            addr_q <= wb_address;
            wdata_q <= wb_wdata;
            age <= '0;
         end
         if (state_nx == PF) addr_q <= pf_address;
      end
`ifdef PMEM_SCHED_PERF_EN
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         perf_dem_wait <= '0;
         perf_pf_grants <= '0;
      end else begin
         if (dem_req && state != DEM) perf_dem_wait <= perf_dem_wait + 32'd1;
         if (state == IDLE && state_nx == PF) perf_pf_grants <= perf_pf_grants + 32'd1;
      end
`else
   assign perf_dem_wait = '0;
   assign perf_pf_grants = '0;
`endif
endmodule

// File: tb/tb_pmem_scheduler.sv
// tb_pmem_scheduler: directed and randomized checks of pmem_scheduler against a
// transaction-level arbitration/memory model and a latency-randomized pmem responder.
module tb_pmem_scheduler;
   localparam int W = 256;
   localparam int AGE_MAX = 4;
`ifdef PMEM_SCHED_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif
   typedef struct {logic [31:0] a; logic [W-1:0] d; bit rd; bit wr;} txn_t;
   logic clk = 1'b0, reset = 1'b1;
   logic [31:0] dem_address = '0, wb_address = '0, pf_address = '0;
   logic dem_read = 1'b0, dem_write = 1'b0, wb_write = 1'b0, pf_read = 1'b0, pmem_resp = 1'b0;
   logic [W-1:0] dem_wdata = '0, wb_wdata = '0, pmem_rdata = '0;
   logic [W-1:0] dem_rdata, pf_rdata, pmem_wdata;
   logic dem_resp, wb_resp, pf_resp, pmem_read, pmem_write;
   logic [31:0] pmem_address, perf_dem_wait, perf_pf_grants;
   logic [1:0] grant;
   txn_t dq[$], wq[$], pq[$];
   int seq[$];
   logic [W-1:0] ref_mem[bit [26:0]];
   logic [W-1:0] pm_mem[bit [26:0]];
   int n_assert = 0, n_fail = 0, age_m = 0, pfg_m = 0, lat_cfg = 0;
   bit stray_req = 1'b0;

   pmem_scheduler #(.WIDTH(W), .WB_AGE_MAX(AGE_MAX)) dut (
      .clk(clk), .reset(reset),
      .dem_address(dem_address), .dem_read(dem_read), .dem_write(dem_write),
      .dem_wdata(dem_wdata), .dem_rdata(dem_rdata), .dem_resp(dem_resp),
      .wb_address(wb_address), .wb_write(wb_write), .wb_wdata(wb_wdata), .wb_resp(wb_resp),
      .pf_address(pf_address), .pf_read(pf_read), .pf_rdata(pf_rdata), .pf_resp(pf_resp),
      .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
      .grant(grant), .perf_dem_wait(perf_dem_wait), .perf_pf_grants(perf_pf_grants)
   );

   initial forever #5 clk = ~clk;

   function automatic logic [W-1:0] pat(logic [31:0] a);
      return {8{{5'd0, a[31:5]} ^ 32'h5a5a_c3c3}};
   endfunction

   function automatic logic [W-1:0] ref_rd(logic [31:0] a);
      return ref_mem.exists(a[31:5]) ? ref_mem[a[31:5]] : pat(a);
   endfunction

   function automatic logic [W-1:0] rnd_line();
      logic [W-1:0] r;
      for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   function automatic logic [31:0] rnd_addr();
      return 32'h0001_0000 + 32'($urandom_range(7, 0)) * 32 + 32'($urandom_range(31, 0));
   endfunction

   // memory device: answers each strobe after 1..4 cycles (or lat_cfg when set)
   initial begin : responder
      int cnt, lat;
      cnt = 0;
      lat = 1;
      forever begin
         @(negedge clk);
         if (pmem_resp) begin
            pmem_resp = 1'b0;
            cnt = 0;
         end else if (stray_req) begin
            pmem_resp = 1'b1;
            stray_req = 1'b0;
         end else if (pmem_read || pmem_write) begin
            cnt++;
            if (cnt == 1) lat = lat_cfg > 0 ? lat_cfg : int'($urandom_range(4, 1));
            if (cnt >= lat) begin
               if (pmem_write) pm_mem[pmem_address[31:5]] = pmem_wdata;
               else pmem_rdata = pm_mem.exists(pmem_address[31:5]) ? pm_mem[pmem_address[31:5]] : pat(pmem_address);
               pmem_resp = 1'b1;
            end
         end else cnt = 0;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // arbitration rules applied to the requests pending at the IDLE decision
   function automatic int pick();
      bit d, w, p;
      d = dq.size() > 0;
      w = wq.size() > 0;
      p = pq.size() > 0;
      if (w && age_m == AGE_MAX) return 2;
      if (d && dq[0].rd && w && dq[0].a[31:5] == wq[0].a[31:5]) return 2;
      return d ? 1 : w ? 2 : p ? 3 : 0;
   endfunction

   task automatic present();
      dem_read = dq.size() > 0 && dq[0].rd;
      dem_write = dq.size() > 0 && dq[0].wr;
      if (dq.size() > 0) begin
         dem_address = dq[0].a;
         dem_wdata = dq[0].d;
      end
      wb_write = wq.size() > 0;
      if (wq.size() > 0) begin
         wb_address = wq[0].a;
         wb_wdata = wq[0].d;
      end
      pf_read = pq.size() > 0;
      if (pq.size() > 0) pf_address = pq[0].a;
   endtask

   task automatic check_resp();
      int e, k;
      txn_t h;
      logic [2:0] v;
      e = pick();
      v = {dem_resp, wb_resp, pf_resp};
      chk("owner_resp", W'(v), W'(e == 1 ? 3'b100 : e == 2 ? 3'b010 : e == 3 ? 3'b001 : 3'b000));
      chk("grant", W'(grant), W'(e));
      if (e == 1 && wq.size() > 0 && age_m < AGE_MAX) age_m++;
      if (e == 2) age_m = 0;
      if (e == 3) pfg_m++;
      k = v == 3'b100 ? 1 : v == 3'b010 ? 2 : v == 3'b001 ? 3 : e;
      seq.push_back(k);
      if (k == 1 && dq.size() > 0) h = dq.pop_front();
      else if (k == 2 && wq.size() > 0) h = wq.pop_front();
      else if (k == 3 && pq.size() > 0) h = pq.pop_front();
      else return;
      chk("pmem_address", W'(pmem_address), W'(h.a));
      chk("pmem_strobes", W'({pmem_read, pmem_write}), W'({h.rd, h.wr && !h.rd}));
      if (h.wr && !h.rd) begin
         chk("pmem_wdata", pmem_wdata, h.d);
         ref_mem[h.a[31:5]] = h.d;
      end else if (k == 3) chk("pf_rdata", pf_rdata, ref_rd(h.a));
      else chk("dem_rdata", dem_rdata, ref_rd(h.a));
   endtask

   task automatic run();
      int budget;
      budget = 3000;
      seq.delete();
      present();
      while (dq.size() + wq.size() + pq.size() > 0 && budget > 0) begin
         tick();
         budget--;
         if (dem_resp || wb_resp || pf_resp) begin
            check_resp();
            present();
         end
      end
      chk("run_within_budget", W'(budget > 0), W'(1));
      dq.delete();
      wq.delete();
      pq.delete();
      present();
      tick();
      tick();
   endtask

   task automatic rnd_fill(input int nd, input int nw, input int np);
      for (int i = 0; i < nd; i++) begin
         int kind;
         kind = int'($urandom_range(2, 0));
         dq.push_back('{rnd_addr(), rnd_line(), kind != 1, kind != 0});
      end
      for (int i = 0; i < nw; i++) wq.push_back('{rnd_addr(), rnd_line(), 1'b0, 1'b1});
      for (int i = 0; i < np; i++) pq.push_back('{rnd_addr(), '0, 1'b1, 1'b0});
   endtask

   initial begin : main
      int hi, t;
      tick();
      tick();
      chk("rst_grant", W'(grant), W'(0));
      chk("rst_strobes", W'({pmem_read, pmem_write}), W'(0));
      chk("rst_resps", W'({dem_resp, wb_resp, pf_resp}), W'(0));
      chk("rst_pmem_address", W'(pmem_address), W'(0));
      chk("rst_pmem_wdata", pmem_wdata, W'(0));
      chk("rst_perf", W'({perf_dem_wait, perf_pf_grants}), W'(0));
      reset = 1'b0;
      tick();
      // lone demand read
      pm_mem[27'(32'h1000 >> 5)] = {32{8'hA5}};
      ref_mem[27'(32'h1000 >> 5)] = {32{8'hA5}};
      lat_cfg = 4;
      dem_address = 32'h0000_1000;
      dem_read = 1'b1;
      tick();
      chk("t1_grant_dem", W'(grant), W'(1));
      chk("t1_pmem_read", W'(pmem_read), W'(1));
      chk("t1_pmem_address", W'(pmem_address), W'(32'h1000));
      hi = 1;
      t = 0;
      while (!dem_resp && t < 20) begin
         tick();
         t++;
         if (pmem_read) hi++;
      end
      chk("t1_strobe_cycles", W'(hi), W'(4));
      chk("t1_dem_resp", W'(dem_resp), W'(1));
      chk("t1_dem_rdata", dem_rdata, {32{8'hA5}});
      dem_read = 1'b0;
      tick();
      chk("t1_resp_one_cycle", W'(dem_resp), W'(0));
      chk("t1_grant_idle", W'(grant), W'(0));
      chk("t1_read_low", W'(pmem_read), W'(0));
      // simultaneous demand and writeback to different lines
      lat_cfg = 0;
      dq.push_back('{32'h2000, rnd_line(), 1'b1, 1'b0});
      wq.push_back('{32'h3000, rnd_line(), 1'b0, 1'b1});
      run();
      chk("t2_first_dem", W'(seq[0]), W'(1));
      chk("t2_then_wb", W'(seq[1]), W'(2));
      // same-line hazard: writeback must precede the read
      dq.push_back('{32'h4010, rnd_line(), 1'b1, 1'b0});
      wq.push_back('{32'h4000, rnd_line(), 1'b0, 1'b1});
      run();
      chk("t3_first_wb", W'(seq[0]), W'(2));
      chk("t3_then_dem", W'(seq[1]), W'(1));
      // writeback aging against a stream of demand reads
      wq.push_back('{32'h8000, rnd_line(), 1'b0, 1'b1});
      for (int i = 0; i < 5; i++) dq.push_back('{32'h9000 + 32'(i) * 32, rnd_line(), 1'b1, 1'b0});
      run();
      chk("t4_count", W'(seq.size()), W'(6));
      chk("t4_fourth_dem", W'(seq[3]), W'(1));
      chk("t4_wb_fifth", W'(seq[4]), W'(2));
      // in-flight prefetch is not preempted
      lat_cfg = 3;
      pf_address = 32'h5000;
      pf_read = 1'b1;
      tick();
      chk("t5_grant_pf", W'(grant), W'(3));
      dem_address = 32'h6000;
      dem_read = 1'b1;
      t = 0;
      while (!pf_resp && t < 20) begin
         tick();
         t++;
      end
      chk("t5_pf_resp", W'({dem_resp, pf_resp}), W'(2'b01));
      chk("t5_pf_rdata", pf_rdata, ref_rd(32'h5000));
      pfg_m++;
      pf_read = 1'b0;
      tick();
      chk("t5_grant_gap", W'(grant), W'(0));
      tick();
      chk("t5_grant_dem", W'(grant), W'(1));
      t = 0;
      while (!dem_resp && t < 20) begin
         tick();
         t++;
      end
      chk("t5_dem_rdata", dem_rdata, ref_rd(32'h6000));
      dem_read = 1'b0;
      tick();
      // randomized mixes
      lat_cfg = 0;
      for (int r = 0; r < 10; r++) begin
         rnd_fill(int'($urandom_range(6, 0)), int'($urandom_range(4, 0)), int'($urandom_range(3, 0)));
         run();
      end
      chk("perf_pf_grants", W'(perf_pf_grants), W'(PERF ? pfg_m : 0));
      // reset in the middle of a writeback
      lat_cfg = 10;
      wb_address = 32'h7000;
      wb_wdata = rnd_line();
      wb_write = 1'b1;
      tick();
      chk("t6_grant_wb", W'(grant), W'(2));
      chk("t6_pmem_write", W'(pmem_write), W'(1));
      tick();
      reset = 1'b1;
      #1;
      chk("t6_write_dropped", W'(pmem_write), W'(0));
      chk("t6_grant_cleared", W'(grant), W'(0));
      wb_write = 1'b0;
      age_m = 0;
      pfg_m = 0;
      tick();
      reset = 1'b0;
      tick();
      stray_req = 1'b1;
      tick();
      chk("t6_stray_ignored", W'({dem_resp, wb_resp, pf_resp}), W'(0));
      chk("t6_stray_grant", W'(grant), W'(0));
      chk("t6_perf_cleared", W'({perf_dem_wait, perf_pf_grants}), W'(0));
      tick();
      lat_cfg = 0;
      rnd_fill(4, 3, 2);
      run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
